// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU/compare datapath: default widths, serializer FSM
// encoding and word-count helpers.
package alu_sys_pkg;

  localparam int unsigned ALU_OUT_WIDTH  = 16;
  localparam int unsigned ALU_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StSend    = 2'b01,
    StSendChk = 2'b10
  } ser_state_e;

  function automatic int unsigned nwords(input int unsigned out_width,
                                         input int unsigned data_width);
    return out_width / data_width;
  endfunction

  // Word counter needs at least one bit even for a single-word result.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// Result-in / word-out bundle of the ALU result serializer. The serializer takes the
// slave view; the ALU side plus TX FIFO write side take the master view.
interface alu_result_serializer_if #(
  parameter int unsigned OUT_WIDTH  = alu_sys_pkg::ALU_OUT_WIDTH,
  parameter int unsigned DATA_WIDTH = alu_sys_pkg::ALU_DATA_WIDTH
);
  logic [OUT_WIDTH-1:0]  ALU_OUT;
  logic                  OUT_VALID;
  logic                  TX_READY;
  logic                  OVR_CLR;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  BUSY;
  logic                  OVERRUN;

  modport master (
    output ALU_OUT, OUT_VALID, TX_READY, OVR_CLR,
    input  TX_DATA, TX_VALID, BUSY, OVERRUN
  );

  modport slave (
    input  ALU_OUT, OUT_VALID, TX_READY, OVR_CLR,
    output TX_DATA, TX_VALID, BUSY, OVERRUN
  );
endinterface

// File: rtl/alu_result_serializer_ser_word_mux.sv
// Selects one DATA_WIDTH word of the held result by word index (word 0 = LSBs).
module ser_word_mux #(
  parameter int unsigned OUT_WIDTH  = alu_sys_pkg::ALU_OUT_WIDTH,
  parameter int unsigned DATA_WIDTH = alu_sys_pkg::ALU_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 1
) (
  input  logic [OUT_WIDTH-1:0]  i_hold,
  input  logic [CNT_WIDTH-1:0]  i_idx,
  output logic [DATA_WIDTH-1:0] o_word
);
  localparam int unsigned NWords = OUT_WIDTH / DATA_WIDTH;

  always_comb begin
    o_word = '0;
    for (int i = 0; i < NWords; i++) begin
      if (i_idx == CNT_WIDTH'(i)) o_word = i_hold[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule

// File: rtl/alu_result_serializer.sv
// Splits each ALU result into DATA_WIDTH words (LSW first) for the TX FIFO.
// Define ALU_SER_CHKSUM_EN to append an XOR checksum word after each result.
module alu_result_serializer
  import alu_sys_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = ALU_OUT_WIDTH,
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
  input logic                   CLK,
  input logic                   RST,
  alu_result_serializer_if.slave ser_bus
);
  localparam int unsigned NWords = nwords(OUT_WIDTH, DATA_WIDTH);
  localparam int unsigned CntW   = cnt_width(NWords);

  ser_state_e            r_state, w_state_d;
  logic [OUT_WIDTH-1:0]  r_hold, w_hold_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d, w_cnt_inc;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_d;
  logic                  r_tx_valid, r_busy, r_overrun, w_overrun_d;
  logic                  w_xfer, w_last, w_accept, w_ovr_set;
  logic [DATA_WIDTH-1:0] w_next_word;

  assign w_xfer    = r_tx_valid & ser_bus.TX_READY;
  assign w_last    = (r_cnt == CntW'(NWords - 1));
  assign w_cnt_inc = r_cnt + CntW'(1);

  ser_word_mux #(
    .OUT_WIDTH  (OUT_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CntW)
  ) u_word_mux (
    .i_hold (r_hold),
    .i_idx  (w_cnt_inc),
    .o_word (w_next_word)
  );

`ifdef ALU_SER_CHKSUM_EN
  logic [DATA_WIDTH-1:0] w_chk;

  always_comb begin
    w_chk = '0;
    for (int i = 0; i < NWords; i++) w_chk ^= r_hold[i*DATA_WIDTH +: DATA_WIDTH];
  end
`endif

  always_comb begin
    w_state_d   = r_state;
    w_hold_d    = r_hold;
    w_cnt_d     = r_cnt;
    w_tx_data_d = r_tx_data;
    w_accept    = 1'b0;
    w_ovr_set   = 1'b0;

    unique case (r_state)
      StIdle: w_accept = ser_bus.OUT_VALID;
      StSend: begin
        if (w_xfer && !w_last) begin
          w_cnt_d     = w_cnt_inc;
          w_tx_data_d = w_next_word;
          w_ovr_set   = ser_bus.OUT_VALID;
        end else if (w_xfer) begin
`ifdef ALU_SER_CHKSUM_EN
          w_state_d   = StSendChk;
          w_tx_data_d = w_chk;
          w_ovr_set   = ser_bus.OUT_VALID;
`else
          w_state_d = StIdle;
          w_accept  = ser_bus.OUT_VALID;
`endif
        end else begin
          w_ovr_set = ser_bus.OUT_VALID;
        end
      end
`ifdef ALU_SER_CHKSUM_EN
      StSendChk: begin
        if (w_xfer) begin
          w_state_d = StIdle;
          w_accept  = ser_bus.OUT_VALID;
        end else begin
          w_ovr_set = ser_bus.OUT_VALID;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase

    // A result accepted on the final transfer restarts SEND with no idle gap.
    if (w_accept) begin
      w_hold_d    = ser_bus.ALU_OUT;
      w_cnt_d     = '0;
      w_state_d   = StSend;
      w_tx_data_d = ser_bus.ALU_OUT[DATA_WIDTH-1:0];
    end
  end

  // Set wins over a same-cycle clear.
  assign w_overrun_d = w_ovr_set | (r_overrun & ~ser_bus.OVR_CLR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= StIdle;
      r_hold     <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_hold     <= w_hold_d;
      r_cnt      <= w_cnt_d;
      r_tx_data  <= w_tx_data_d;
      r_tx_valid <= (w_state_d != StIdle);
      r_busy     <= (w_state_d != StIdle);
      r_overrun  <= w_overrun_d;
    end
  end

  assign ser_bus.TX_DATA  = r_tx_data;
  assign ser_bus.TX_VALID = r_tx_valid;
  assign ser_bus.BUSY     = r_busy;
  assign ser_bus.OVERRUN  = r_overrun;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed scenarios plus a randomized run checked
// against a queue-based model of the emitted word stream.
module tb_alu_result_serializer;

`ifdef ALU_SER_CHKSUM_EN
  localparam int NT = 3;
`else
  localparam int NT = 2;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  alu_result_serializer_if #(.OUT_WIDTH(16), .DATA_WIDTH(8)) bus ();

  alu_result_serializer #(.OUT_WIDTH(16), .DATA_WIDTH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ser_bus (bus)
  );

  function automatic logic [7:0] word_of(input logic [15:0] v, input int k);
    if (k == 0) return v[7:0];
    if (k == 1) return v[15:8];
    return v[7:0] ^ v[15:8];
  endfunction

  // Model: words still owed downstream; a new result fits only when nothing is owed
  // or the last owed word leaves on this very edge.
  logic [7:0] mq[$];
  bit         m_ovr = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin : model_step
      bit xfer, room;
      xfer = (mq.size() > 0) && bus.TX_READY;
      room = (mq.size() == 0) || (xfer && mq.size() == 1);
      if (xfer) void'(mq.pop_front());
      if (bus.OVR_CLR) m_ovr = 1'b0;
      if (bus.OUT_VALID) begin
        if (room) for (int k = 0; k < NT; k++) mq.push_back(word_of(bus.ALU_OUT, k));
        else m_ovr = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus.ALU_OUT = '0; bus.OUT_VALID = 1'b0; bus.TX_READY = 1'b1; bus.OVR_CLR = 1'b0;
    #12;
    n_chk++; if (bus.TX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.TX_DATA); end
    n_chk++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.TX_VALID); end
    n_chk++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    n_chk++; if (bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", bus.OVERRUN); end
    tick();
    RST = 1'b1;
    tick();
    n_chk++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", bus.TX_VALID); end
  endtask

  task automatic test_basic();
    bus.ALU_OUT = 16'hA55A; bus.OUT_VALID = 1'b1; bus.TX_READY = 1'b1;
    tick();
    bus.OUT_VALID = 1'b0;
    for (int k = 0; k < NT; k++) begin
      n_chk++; if (bus.TX_VALID !== 1'b1 || bus.BUSY !== 1'b1 || bus.TX_DATA !== word_of(16'hA55A, k)) begin
        n_fail++; $display("FAIL basic_word%0d: got v=%b b=%b d=%h want v=1 b=1 d=%h",
                           k, bus.TX_VALID, bus.BUSY, bus.TX_DATA, word_of(16'hA55A, k));
      end
      tick();
    end
    n_chk++; if (bus.TX_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL basic_end: got v=%b b=%b want 0 0", bus.TX_VALID, bus.BUSY);
    end
  endtask

  task automatic test_backpressure();
    bus.ALU_OUT = 16'h1234; bus.OUT_VALID = 1'b1; bus.TX_READY = 1'b0;
    tick();
    bus.OUT_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'h34) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=34", i, bus.TX_VALID, bus.TX_DATA);
      end
      tick();
    end
    bus.TX_READY = 1'b1;
    n_chk++; if (bus.TX_DATA !== 8'h34) begin n_fail++; $display("FAIL bp_release: got %h want 34", bus.TX_DATA); end
    tick();
    for (int k = 1; k < NT; k++) begin
      n_chk++; if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== word_of(16'h1234, k)) begin
        n_fail++; $display("FAIL bp_word%0d: got v=%b d=%h want v=1 d=%h", k, bus.TX_VALID, bus.TX_DATA,
                           word_of(16'h1234, k));
      end
      tick();
    end
    n_chk++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_end: got %b want 0", bus.TX_VALID); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [2];
    vals[0] = 16'h0001; vals[1] = 16'h0003;
    bus.ALU_OUT = vals[0]; bus.OUT_VALID = 1'b1; bus.TX_READY = 1'b1;
    tick();
    bus.OUT_VALID = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NT; k++) begin
        n_chk++; if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== word_of(vals[r], k)) begin
          n_fail++; $display("FAIL b2b_r%0d_w%0d: got v=%b d=%h want v=1 d=%h", r, k, bus.TX_VALID,
                             bus.TX_DATA, word_of(vals[r], k));
        end
        if (r == 0 && k == NT - 1) begin bus.ALU_OUT = vals[1]; bus.OUT_VALID = 1'b1; end
        tick();
        bus.OUT_VALID = 1'b0;
      end
    end
    n_chk++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", bus.TX_VALID); end
    n_chk++; if (bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr: got %b want 0", bus.OVERRUN); end
  endtask

  task automatic test_overrun();
    bus.ALU_OUT = 16'h0002; bus.OUT_VALID = 1'b1; bus.TX_READY = 1'b1;
    tick();
    bus.ALU_OUT = 16'hFFFF;
    for (int k = 0; k < NT; k++) begin
      n_chk++; if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== word_of(16'h0002, k)) begin
        n_fail++; $display("FAIL ovr_word%0d: got v=%b d=%h want v=1 d=%h", k, bus.TX_VALID, bus.TX_DATA,
                           word_of(16'h0002, k));
      end
      tick();
      bus.OUT_VALID = 1'b0;
    end
    n_chk++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL ovr_dropped: got %b want 0", bus.TX_VALID); end
    tick(); tick();
    n_chk++; if (bus.OVERRUN !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", bus.OVERRUN); end
    bus.OVR_CLR = 1'b1;
    tick();
    bus.OVR_CLR = 1'b0;
    n_chk++; if (bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", bus.OVERRUN); end
    // Clear and a fresh overrun on the same edge.
    bus.ALU_OUT = 16'h0005; bus.OUT_VALID = 1'b1;
    tick();
    bus.OVR_CLR = 1'b1;
    tick();
    bus.OUT_VALID = 1'b0; bus.OVR_CLR = 1'b0;
    n_chk++; if (bus.OVERRUN !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b want 1", bus.OVERRUN); end
    for (int i = 0; i < NT + 1; i++) tick();
    bus.OVR_CLR = 1'b1;
    tick();
    bus.OVR_CLR = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.ALU_OUT = 16'hBEEF; bus.OUT_VALID = 1'b1; bus.TX_READY = 1'b1;
    tick();
    bus.OUT_VALID = 1'b0;
    n_chk++; if (bus.TX_VALID !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %b want 1", bus.TX_VALID); end
    #2 RST = 1'b0;
    #1;
    n_chk++; if (bus.TX_VALID !== 1'b0 || bus.TX_DATA !== 8'h00 || bus.BUSY !== 1'b0 || bus.OVERRUN !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: got v=%b d=%h b=%b o=%b want all 0", bus.TX_VALID, bus.TX_DATA,
                         bus.BUSY, bus.OVERRUN);
    end
    tick(); tick();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet%0d: got %b want 0", i, bus.TX_VALID); end
    end
  endtask

`ifdef ALU_SER_CHKSUM_EN
  task automatic test_checksum();
    logic [7:0] exp_w [3];
    exp_w[0] = 8'h3C; exp_w[1] = 8'h0F; exp_w[2] = 8'h33;
    bus.ALU_OUT = 16'h0F3C; bus.OUT_VALID = 1'b1; bus.TX_READY = 1'b1;
    tick();
    bus.OUT_VALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== exp_w[k]) begin
        n_fail++; $display("FAIL chk_word%0d: got v=%b d=%h want v=1 d=%h", k, bus.TX_VALID, bus.TX_DATA, exp_w[k]);
      end
      tick();
    end
    n_chk++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL chk_end: got %b want 0", bus.TX_VALID); end
  endtask
`endif

  task automatic test_random();
    bit exp_v;
    for (int c = 0; c < 400; c++) begin
      bus.TX_READY  = ($urandom_range(0, 3) != 0);
      bus.OUT_VALID = ($urandom_range(0, 3) == 0);
      bus.ALU_OUT   = 16'($urandom);
      bus.OVR_CLR   = ($urandom_range(0, 15) == 0);
      tick();
      exp_v = (mq.size() > 0);
      n_chk++; if (bus.TX_VALID !== exp_v || bus.BUSY !== exp_v) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got v=%b b=%b want %b", c, bus.TX_VALID, bus.BUSY, exp_v);
      end
      if (exp_v) begin
        n_chk++; if (bus.TX_DATA !== mq[0]) begin
          n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, bus.TX_DATA, mq[0]);
        end
      end
      n_chk++; if (bus.OVERRUN !== m_ovr) begin
        n_fail++; $display("FAIL rnd_ovr c%0d: got %b want %b", c, bus.OVERRUN, m_ovr);
      end
    end
    bus.OUT_VALID = 1'b0; bus.OVR_CLR = 1'b0; bus.TX_READY = 1'b1;
    for (int i = 0; i < NT + 2; i++) tick();
    n_chk++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: got %b want 0", bus.TX_VALID); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef ALU_SER_CHKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream stage of the ALU/compare unit, in the REF_CLK domain.
- Captures each registered ALU result (OUT_WIDTH bits, qualified by a one-cycle OUT_VALID pulse).
- Emits the result as DATA_WIDTH-bit words, least-significant word first, over a valid/ready handshake into the TX async FIFO write side.
- Flags results that arrive while a previous result is still being emitted.

Parameters:
OUT_WIDTH, 16, width of the ALU result; must be an integer multiple of DATA_WIDTH
DATA_WIDTH, 8, width of each emitted word (FIFO/UART width)

Ports:
CLK  input  1  REF_CLK domain clock
RST  input  1  reset, asynchronous, active-low
ALU_OUT  input  OUT_WIDTH  registered ALU result
OUT_VALID  input  1  one-cycle pulse qualifying ALU_OUT
TX_READY  input  1  downstream can accept a word this cycle (FIFO not full)
OVR_CLR  input  1  synchronous clear of OVERRUN
TX_DATA  output  DATA_WIDTH  current word
TX_VALID  output  1  TX_DATA valid
BUSY  output  1  high whenever the FSM is not in IDLE
OVERRUN  output  1  sticky flag: a result was dropped

Behaviour:
- Reset (RST low, asynchronous):
  - TX_DATA=0, TX_VALID=0, BUSY=0, OVERRUN=0.
  - Hold register=0, word counter=0, FSM=IDLE.
  - Reset mid-transfer aborts it; no partial words are emitted after release.
- All outputs are driven from registers; there is no combinational path from any input to any output.
- Handshake:
  - A word transfers on a CLK edge where TX_VALID and TX_READY are both high.
  - Once TX_VALID is asserted, TX_DATA is held stable and TX_VALID stays high until the transfer completes.
- NWORDS = OUT_WIDTH/DATA_WIDTH (2 by default). The counter width is clog2(NWORDS), minimum 1.
- FSM states: IDLE, SEND (plus SEND_CHK with the optional feature).
- IDLE:
  - On OUT_VALID, latch ALU_OUT into the hold register and go to SEND.
  - Next cycle: TX_DATA = hold[DATA_WIDTH-1:0], TX_VALID=1, BUSY=1, counter=0.
  - Latency from OUT_VALID to first TX_VALID is 1 cycle.
- SEND, on each transfer:
  - If counter < NWORDS-1: increment counter; TX_DATA becomes the next word up, presented the cycle after the transfer.
  - If counter == NWORDS-1: deassert TX_VALID and go to IDLE (or SEND_CHK).
- Back-to-back results:
  - If OUT_VALID coincides with the final transfer, the new result is latched.
  - The FSM then returns to SEND with counter=0, so its first word is valid on the next cycle with no idle gap.
  - Sustained throughput is one result per NWORDS cycles when TX_READY is held high.
- Overrun:
  - OUT_VALID in SEND (other than on the final transfer) or in SEND_CHK is dropped. The hold register is unchanged and OVERRUN is set.
  - OVERRUN stays set until OVR_CLR or reset.
  - OVR_CLR and a new overrun in the same cycle leave OVERRUN=1 (set wins).
- TX_READY low stalls indefinitely; no timeout.
- OUT_VALID held high for several cycles counts as one result per cycle; all but the accepted one are overruns.

Optional Feature:
- Macro: ALU_SER_CHKSUM_EN.
- When defined:
  - After the last data word, the FSM enters SEND_CHK.
  - It emits one extra word: the XOR of all NWORDS data words, same handshake.
  - The final transfer for back-to-back acceptance is the checksum transfer.
  - Throughput becomes NWORDS+1 cycles per result.
- When undefined: the SEND_CHK state and checksum logic are absent, and behaviour is exactly as above.

Decomposition:
- Shared package alu_sys_pkg holds:
  - FSM state typedef/encoding (IDLE=2'b00, SEND=2'b01, SEND_CHK=2'b10).
  - Default OUT_WIDTH/DATA_WIDTH constants, shared with the ALU and CMP units.
  - NWORDS function.
- One natural sub-module: ser_word_mux, which selects the word by counter index from the hold register.
- The FSM stays in the top module.

Test Plan:
- Reset mid-transfer: RST low while TX_VALID=1 -> all outputs 0 asynchronously. After release, no word appears until a new OUT_VALID.
- Basic: ALU_OUT=16'hA55A, OUT_VALID pulse, TX_READY=1 -> TX_DATA 8'h5A then 8'hA5 on consecutive cycles, TX_VALID for exactly 2 cycles, BUSY=1 for 2 cycles.
- Backpressure: ALU_OUT=16'h1234, TX_READY low for 5 cycles after the first TX_VALID -> TX_DATA held at 8'h34, then 8'h12 after TX_READY rises. No loss or duplication.
- Back-to-back: 16'h0001, then 16'h0003 pulsed on the cycle of the final transfer -> words 01,00,03,00 with TX_VALID continuously high. OVERRUN=0.
- Overrun: second OUT_VALID with 16'hFFFF one cycle after the first (16'h0002) -> only 02,00 emitted; OVERRUN=1 until an OVR_CLR pulse clears it.
- Checksum (ALU_SER_CHKSUM_EN): ALU_OUT=16'h0F3C -> words 3C, 0F, 33; TX_VALID for 3 cycles.
